// File: rtl/cmp_pkg.sv
// ============================================================================
//  Module   : cmp_pkg
//  Brief    : Shared constants, state encoding and golden compare function
//             for the comparator sweep checker.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package cmp_pkg;

    localparam int CMP_W     = 6;
    localparam int CMP_ARG_W = 16;

    // Result vector bit positions
    localparam int RES_EQ = 2;
    localparam int RES_GT = 1;
    localparam int RES_LT = 0;

    typedef logic [2:0] cmp_res_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } cmp_state_t;

    function automatic cmp_res_t golden_compare(
        input logic [CMP_ARG_W-1:0] a,
        input logic [CMP_ARG_W-1:0] b
    );
        cmp_res_t r;
        r         = '0;
        r[RES_EQ] = (a == b);
        r[RES_GT] = (a > b);
        r[RES_LT] = (a < b);
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cmp_expect_pipe.sv
// ============================================================================
//  Module   : cmp_expect_pipe
//  Brief    : LAT-deep delay line of {valid, a, b}; pure pass-through at LAT=0.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module cmp_expect_pipe #(
    parameter int W   = 6,
    parameter int LAT = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_valid,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic         o_valid,
    output logic [W-1:0] o_a,
    output logic [W-1:0] o_b
);

    generate
        if (LAT == 0) begin : g_passthru
            logic w_unused;
            assign w_unused = &{1'b0, clk, rst};
            assign o_valid  = i_valid;
            assign o_a      = i_a;
            assign o_b      = i_b;
        end else begin : g_delay
            logic [LAT-1:0] r_vld;
            logic [W-1:0]   r_a [LAT];
            logic [W-1:0]   r_b [LAT];

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_vld <= '0;
                end else begin
                    r_vld[0] <= i_valid;
                    for (int i = 1; i < LAT; i++) begin
                        r_vld[i] <= r_vld[i-1];
                    end
                end
            end

            // Operand payload needs no reset; only the valid bits qualify it
            always_ff @(posedge clk) begin
                r_a[0] <= i_a;
                r_b[0] <= i_b;
                for (int i = 1; i < LAT; i++) begin
                    r_a[i] <= r_a[i-1];
                    r_b[i] <= r_b[i-1];
                end
            end

            assign o_valid = r_vld[LAT-1];
            assign o_a     = r_a[LAT-1];
            assign o_b     = r_b[LAT-1];
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/comparator_sweep_checker.sv
// ============================================================================
//  Module   : comparator_sweep_checker
//  Brief    : On-chip exhaustive sweep and response checker for a W-bit
//             magnitude comparator with LAT cycles of response latency.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module comparator_sweep_checker
    import cmp_pkg::*;
#(
    parameter int W     = CMP_W,
    parameter int LAT   = 0,
    parameter int ERR_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [W-1:0]     dut_a,
    output logic [W-1:0]     dut_b,
    input  logic             dut_eq,
    input  logic             dut_gt,
    input  logic             dut_lt,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic             first_err_valid,
    output logic [W-1:0]     first_err_a,
    output logic [W-1:0]     first_err_b
);

    localparam logic [W-1:0] c_MAX      = '1;
    localparam int           c_DRN_W    = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [c_DRN_W-1:0] c_DRN_LAST = c_DRN_W'((LAT > 0) ? LAT - 1 : 0);

    cmp_state_t         r_state;
    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;
    logic               r_busy;
    logic               r_done;
    logic               r_pass;
    logic [ERR_W-1:0]   r_err_count;
    logic               r_fev;
    logic [W-1:0]       r_fea;
    logic [W-1:0]       r_feb;
    logic [c_DRN_W-1:0] r_drn;

    logic               w_pres_valid;
    logic               w_chk_valid;
    logic [W-1:0]       w_chk_a;
    logic [W-1:0]       w_chk_b;
    cmp_res_t           w_exp;
    cmp_res_t           w_resp;
    logic               w_mismatch;
    logic [ERR_W-1:0]   w_err_next;
    logic               w_last_pair;

    assign w_pres_valid = (r_state == RUN);

    cmp_expect_pipe #(
        .W   (W),
        .LAT (LAT)
    ) u_expect_pipe (
        .clk     (clk),
        .rst     (rst),
        .i_valid (w_pres_valid),
        .i_a     (r_a),
        .i_b     (r_b),
        .o_valid (w_chk_valid),
        .o_a     (w_chk_a),
        .o_b     (w_chk_b)
    );

    always_comb begin
        w_resp         = '0;
        w_resp[RES_EQ] = dut_eq;
        w_resp[RES_GT] = dut_gt;
        w_resp[RES_LT] = dut_lt;
    end

    assign w_exp       = golden_compare(CMP_ARG_W'(w_chk_a), CMP_ARG_W'(w_chk_b));
    assign w_mismatch  = w_chk_valid && (w_resp != w_exp);
    assign w_err_next  = (w_mismatch && !(&r_err_count)) ? r_err_count + 1'b1 : r_err_count;
    assign w_last_pair = (r_a == c_MAX) && (r_b == c_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_err_count <= '0;
            r_fev       <= 1'b0;
            r_fea       <= '0;
            r_feb       <= '0;
            r_drn       <= '0;
        end else begin
            if (w_mismatch) begin
                r_err_count <= w_err_next;
                if (!r_fev) begin
                    r_fev <= 1'b1;
                    r_fea <= w_chk_a;
                    r_feb <= w_chk_b;
                end
            end

            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_state     <= RUN;
                        r_a         <= '0;
                        r_b         <= '0;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                        r_pass      <= 1'b0;
                        r_err_count <= '0;
                        r_fev       <= 1'b0;
                        r_fea       <= '0;
                        r_feb       <= '0;
                    end
                end
                RUN: begin
                    if (w_last_pair) begin
                        if (LAT == 0) begin
                            // Final pair is checked this very cycle; pass includes it
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= (w_err_next == '0);
                        end else begin
                            r_state <= DRAIN;
                            r_drn   <= '0;
                        end
                    end else begin
                        {r_a, r_b} <= {r_a, r_b} + 1'b1;
                    end
                end
                DRAIN: begin
                    if (r_drn == c_DRN_LAST) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (w_err_next == '0);
                    end else begin
                        r_drn <= r_drn + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign dut_a           = r_a;
    assign dut_b           = r_b;
    assign busy            = r_busy;
    assign done            = r_done;
    assign pass            = r_pass;
    assign err_count       = r_err_count;
    assign first_err_valid = r_fev;
    assign first_err_a     = r_fea;
    assign first_err_b     = r_feb;

endmodule

`default_nettype wire

// File: tb/tb_comparator_sweep_checker.sv
// ============================================================================
//  Module   : tb_comparator_sweep_checker
//  Brief    : Self-checking bench: two checker instances (LAT=0/ERR_W=16 and
//             LAT=2/ERR_W=4) each facing a comparator model with injectable faults.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_comparator_sweep_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic tb_start;
    int   sel;
    int   f_mode, f_a, f_b, f_bit;
    int   n_checks = 0;
    int   n_errors = 0;

    logic        start0, start1;
    logic [5:0]  a0, b0, fa0, fb0, a1, b1, fa1, fb1;
    logic        eq0, gt0, lt0, busy0, done0, pass0, fev0;
    logic        eq1, gt1, lt1, busy1, done1, pass1, fev1;
    logic [15:0] ec0;
    logic [3:0]  ec1;
    logic [2:0]  r1_s1, r1_s2;

    assign start0 = tb_start && (sel == 0);
    assign start1 = tb_start && (sel == 1);

    // Comparator with optional fault: 1 gt stuck-0, 2 eq+gt at one pair,
    // 3 single bit flip at one pair, 4 lt stuck-1
    function automatic logic [2:0] faulty_resp(input int a, input int b, input int mode,
                                               input int fa, input int fb, input int fbit);
        logic [2:0] r;
        r = {a == b, a > b, a < b};
        case (mode)
            1: r[1] = 1'b0;
            2: if (a == fa && b == fb) r = 3'b110;
            3: if (a == fa && b == fb) r[fbit] = ~r[fbit];
            4: r[0] = 1'b1;
            default: ;
        endcase
        return r;
    endfunction

    always_comb {eq0, gt0, lt0} = faulty_resp(int'(a0), int'(b0), f_mode, f_a, f_b, f_bit);

    always @(posedge clk) begin
        r1_s1 <= faulty_resp(int'(a1), int'(b1), f_mode, f_a, f_b, f_bit);
        r1_s2 <= r1_s1;
    end
    assign {eq1, gt1, lt1} = r1_s2;

    comparator_sweep_checker #(.W(6), .LAT(0), .ERR_W(16)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .dut_a(a0), .dut_b(b0),
        .dut_eq(eq0), .dut_gt(gt0), .dut_lt(lt0), .busy(busy0), .done(done0),
        .pass(pass0), .err_count(ec0), .first_err_valid(fev0),
        .first_err_a(fa0), .first_err_b(fb0)
    );

    comparator_sweep_checker #(.W(6), .LAT(2), .ERR_W(4)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .dut_a(a1), .dut_b(b1),
        .dut_eq(eq1), .dut_gt(gt1), .dut_lt(lt1), .busy(busy1), .done(done1),
        .pass(pass1), .err_count(ec1), .first_err_valid(fev1),
        .first_err_a(fa1), .first_err_b(fb1)
    );

    logic [5:0]  m_a, m_b, m_fa, m_fb;
    logic        m_busy, m_done, m_pass, m_fev;
    logic [31:0] m_err;

    always_comb begin
        if (sel == 0) begin
            m_a = a0; m_b = b0; m_fa = fa0; m_fb = fb0;
            m_busy = busy0; m_done = done0; m_pass = pass0; m_fev = fev0;
            m_err = 32'(ec0);
        end else begin
            m_a = a1; m_b = b1; m_fa = fa1; m_fb = fb1;
            m_busy = busy1; m_done = done1; m_pass = pass1; m_fev = fev1;
            m_err = 32'(ec1);
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_ctl"}, {m_busy, m_done, m_pass, m_fev, m_a, m_b}, 32'd0);
        check_val({tag, "_err"}, m_err, 32'd0);
        check_val({tag, "_fe"}, {m_fa, m_fb}, 32'd0);
    endtask

    task automatic run_sweep(input int which, input int mode, input int fa, input int fb,
                             input int fbit, input bit mid_start);
        int         exp_cnt, exp_fa, exp_fb, lat, sat, k, seq_err, busy_err;
        bit         have_first;
        logic [2:0] r, t;
        exp_cnt = 0; exp_fa = 0; exp_fb = 0; have_first = 1'b0;
        for (int a = 0; a < 64; a++) begin
            for (int b = 0; b < 64; b++) begin
                t = {a == b, a > b, a < b};
                r = faulty_resp(a, b, mode, fa, fb, fbit);
                if (r != t) begin
                    if (!have_first) begin
                        have_first = 1'b1; exp_fa = a; exp_fb = b;
                    end
                    exp_cnt++;
                end
            end
        end
        lat = (which == 1) ? 2 : 0;
        sat = (which == 1) ? 15 : 65535;

        sel = which; f_mode = mode; f_a = fa; f_b = fb; f_bit = fbit;
        @(negedge clk);
        tb_start = 1'b1;
        @(posedge clk); #1;
        tb_start = 1'b0;

        k = 0; seq_err = 0; busy_err = 0;
        while (m_done !== 1'b1 && k <= 5000) begin
            if (k < 4096 && ({m_a, m_b} !== 12'(k))) seq_err++;
            if (m_busy !== 1'b1) busy_err++;
            tb_start = mid_start && (k == 50);
            @(posedge clk); #1;
            k++;
        end
        tb_start = 1'b0;

        check_val("done_latency", k, 4096 + lat);
        check_val("pair_sequence_errs", seq_err, 0);
        check_val("busy_gaps", busy_err, 0);
        check_val("busy_at_done", m_busy, 1'b0);
        check_val("pass", m_pass, (exp_cnt == 0));
        check_val("err_count", m_err, (exp_cnt > sat) ? sat : exp_cnt);
        check_val("first_err_valid", m_fev, have_first);
        if (have_first) begin
            check_val("first_err_a", m_fa, exp_fa);
            check_val("first_err_b", m_fb, exp_fb);
        end
        repeat (3) @(posedge clk);
        #1;
        check_val("done_hold", {m_done, m_busy}, 2'b10);
        check_val("err_hold", m_err, (exp_cnt > sat) ? sat : exp_cnt);
    endtask

    initial begin
        rst = 1'b1; tb_start = 1'b0; sel = 0;
        f_mode = 0; f_a = 0; f_b = 0; f_bit = 0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst0");
        sel = 1; #1;
        check_reset_outputs("rst1");
        rst = 1'b0;

        run_sweep(0, 0, 0, 0, 0, 1'b0);
        run_sweep(0, 1, 0, 0, 0, 1'b0);
        run_sweep(1, 0, 0, 0, 0, 1'b0);
        run_sweep(0, 2, 63, 63, 0, 1'b0);
        run_sweep(1, 1, 0, 0, 0, 1'b1);

        // Reset in the middle of a faulty sweep, then a clean sweep
        sel = 0; f_mode = 1;
        @(negedge clk);
        tb_start = 1'b1;
        @(posedge clk); #1;
        tb_start = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        check_val("pre_rst_busy", m_busy, 1'b1);
        check_val("pre_rst_fev", m_fev, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_reset_outputs("rst_mid");
        run_sweep(0, 0, 0, 0, 0, 1'b0);

        repeat (3) begin
            run_sweep(int'($urandom_range(1, 0)), int'($urandom_range(4, 0)),
                      int'($urandom_range(63, 0)), int'($urandom_range(63, 0)),
                      int'($urandom_range(2, 0)), 1'($urandom_range(1, 0)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/comparator_sweep_checker.md
Name: comparator_sweep_checker

Overview:
- Synthesizable self-test engine for the 6-bit magnitude comparator.
- Drives every (a, b) operand pair into the comparator and checks the returned eq/gt/lt against an internal golden model.
- Reports pass/fail, a saturating error count and the first failing pair.
- Sits beside comparator_6bit as its stimulus source and response checker. It replaces the simulation-only exhaustive sweep with an on-chip equivalent.

Parameters:
- W, 6: operand width. The sweep covers 2^W x 2^W pairs.
- LAT, 0: comparator response latency in clock cycles (0 = combinational DUT).
- ERR_W, 16: width of the saturating error counter.

Ports:
- clk  in  1: clock. All state is updated on the rising edge.
- rst  in  1: synchronous, active-high reset.
- start  in  1: single-cycle request to begin a sweep.
- dut_a  out  W: operand a driven to the comparator (registered).
- dut_b  out  W: operand b driven to the comparator (registered).
- dut_eq  in  1: comparator equal response.
- dut_gt  in  1: comparator greater-than response.
- dut_lt  in  1: comparator less-than response.
- busy  out  1: high while a sweep is in progress.
- done  out  1: high when a sweep has completed; held until the next start or reset.
- pass  out  1: valid when done is high; 1 means zero errors.
- err_count  out  ERR_W: number of mismatching pairs, saturating at all-ones.
- first_err_valid  out  1: high once at least one mismatch has been captured.
- first_err_a  out  W: a operand of the first mismatch.
- first_err_b  out  W: b operand of the first mismatch.

Behaviour:
- Reset values (rst sampled high on an edge): state IDLE; dut_a=0; dut_b=0; busy=0; done=0; pass=0; err_count=0; first_err_valid=0; first_err_a=0; first_err_b=0; all pipeline valid bits=0.
- Reset takes priority over every other event, including reset mid-sweep. The in-flight sweep is abandoned and the pipeline is flushed.
- States:
  - IDLE: start=1 -> RUN; clears err_count, first_err_* and done; dut_a=dut_b=0.
  - RUN: presents one pair per cycle. b is the inner index: b increments each cycle; on b wrap from 2^W-1 to 0, a increments. After presenting pair (2^W-1, 2^W-1): if LAT=0 -> DONE, else -> DRAIN.
  - DRAIN: remains exactly LAT cycles, checking the last LAT responses, then -> DONE.
  - DONE: done=1, busy=0, pass=(err_count==0). start=1 -> RUN with the same clearing as in IDLE.
- busy=1 in RUN and DRAIN. A start pulse during RUN or DRAIN is ignored.
- Operand timing: the pair is registered at dut_a/dut_b. The first pair (0,0) appears in the cycle after start is sampled.
- Expected-value pipeline: the expected result is computed from the presented pair, eq=(a==b), gt=(a>b), lt=(a<b). It travels with the operands through a LAT-deep shift register of {valid, a, b}. At LAT=0 the check is against the currently presented pair in the same cycle.
- Check rule: a checked response mismatches if {dut_eq, dut_gt, dut_lt} differs from the expected value. A non-one-hot response is therefore always an error.
- On mismatch:
  - err_count increments, saturating at 2^ERR_W-1.
  - If first_err_valid=0, the pair is captured and first_err_valid is set.
- Simultaneous events: the last check and the transition to DONE occur in the same cycle. pass reflects that final check.
- Total sweep time: 2^(2W)+LAT cycles from the first pair presentation to done.
  - W=6, LAT=0: done rises 4096 cycles after the first pair.
- err_count is not cleared on DONE. It is cleared only by start or reset.

Decomposition:
- Shared package, cmp_pkg:
  - CMP_W=6 constant.
  - Result-vector encoding: bit2=eq, bit1=gt, bit0=lt.
  - State enum: IDLE, RUN, DRAIN, DONE.
  - golden_compare function returning the 3-bit expected vector.
- One sub-module, cmp_expect_pipe: a parameterised LAT-deep delay line of {valid, a, b}, with a pass-through when LAT=0.

Test Plan:
- Correct DUT, LAT=0, start pulse -> done=1 4096 cycles after the first pair; pass=1; err_count=0; first_err_valid=0.
- DUT with gt stuck-at-0, LAT=0 -> err_count=2016; pass=0; first_err_a=1, first_err_b=0.
- Correct DUT behind a 2-stage register, LAT=2 -> pass=1; done rises 4098 cycles after the first pair; busy is high throughout.
- DUT returning eq=1 and gt=1 only at a=63, b=63 -> err_count=1; first_err_a=63, first_err_b=63; pass=0.
- ERR_W=4 with gt stuck-at-0 -> err_count saturates at 15. Second start pulse issued mid-RUN at cycle 50 -> ignored; the sweep still completes at cycle 4096.
- rst asserted at RUN cycle 100 -> next cycle all outputs hold reset values. A new start then gives a full clean sweep with pass=1.
